// File: rtl/bshift_pipe_if.sv
// bshift_pipe_if: input/output handshake bundle for bshift_pipe; out_carry exists only with BSHIFT_PIPE_CARRY_EN
interface bshift_pipe_if #(
    parameter int WIDTH = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [$clog2(WIDTH)-1:0] in_amt;
    logic [1:0]               in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
`ifdef BSHIFT_PIPE_CARRY_EN
    logic                     out_carry;
    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );
    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
`else
    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/bshift_pipe.sv
// bshift_pipe: pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready backpressure.
// Define BSHIFT_PIPE_CARRY_EN to add out_carry (last bit shifted out).
module bshift_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    bshift_pipe_if.slave io
);
    localparam int L = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        word_t          data;
        logic [L-1:0]   amt;
        logic [1:0]     mode;
        logic           sign;
`ifdef BSHIFT_PIPE_CARRY_EN
        logic           carry;
`endif
    } beat_t;

    logic [STAGES-1:0] valid_q, valid_d, valid_c;
    logic [STAGES:0]   take;
    beat_t             pipe_q [STAGES];
    beat_t             pipe_d [STAGES];
    beat_t             pipe_c [STAGES];
    beat_t             in_beat;
    beat_t             nxt;

    // Right shifts share one path; fill supplies rotate-in bits or sign copies.
    function automatic word_t level(word_t d, int sh, logic [1:0] mode, logic sign);
        word_t ones, fill;
        ones = '1;
        fill = mode == 2'b11 ? d << (WIDTH - sh) : (mode == 2'b10 && sign) ? ~(ones >> sh) : '0;
        return mode == 2'b00 ? d << sh : (d >> sh) | fill;
    endfunction

    always_comb begin
        in_beat      = '0;
        in_beat.data = io.in_data;
        in_beat.amt  = io.in_amt;
        in_beat.mode = io.in_mode;
        in_beat.sign = io.in_data[WIDTH-1];
`ifdef BSHIFT_PIPE_CARRY_EN
        in_beat.carry = io.in_amt == '0 ? 1'b0 :
                        io.in_mode == 2'b00 ? io.in_data[L'(0) - io.in_amt] : io.in_data[io.in_amt - L'(1)];
`endif
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_chain
        if (g == 0) begin : g_in
            assign valid_c[0] = io.in_valid;
            assign pipe_c[0]  = in_beat;
        end else begin : g_mid
            assign valid_c[g] = valid_q[g-1];
            assign pipe_c[g]  = pipe_q[g-1];
        end
    end

    // A stage loads when empty or when its successor takes its beat this cycle.
    always_comb begin
        take[STAGES] = io.out_ready;
        for (int s = STAGES - 1; s >= 0; s--)
            take[s] = !valid_q[s] || take[s+1];
        nxt = '0;
        for (int s = 0; s < STAGES; s++) begin
            nxt = pipe_c[s];
            for (int k = 0; k < L; k++)
                if (k >= s * L / STAGES && k < (s + 1) * L / STAGES && nxt.amt[k])
                    nxt.data = level(nxt.data, 1 << k, nxt.mode, nxt.sign);
            valid_d[s] = take[s] ? valid_c[s] : valid_q[s];
            pipe_d[s]  = take[s] && valid_c[s] ? nxt : pipe_q[s];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++)
                pipe_q[s] <= '0;
        end else begin
            valid_q <= valid_d;
            pipe_q  <= pipe_d;
        end
    end

    assign io.in_ready  = take[0];
    assign io.out_valid = valid_q[STAGES-1];
    assign io.out_data  = pipe_q[STAGES-1].data;
`ifdef BSHIFT_PIPE_CARRY_EN
    assign io.out_carry = pipe_q[STAGES-1].carry;
`endif
endmodule

// File: tb/tb_bshift_pipe.sv
// tb_bshift_pipe: randomized and directed checks of bshift_pipe (WIDTH=16, STAGES=2) against a whole-shift reference model.
module tb_bshift_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bshift_pipe_if #(.WIDTH(W)) bus();
    bshift_pipe #(.WIDTH(W), .STAGES(2)) dut (.clk(clk), .rst(rst), .io(bus));

    logic out_c;
`ifdef BSHIFT_PIPE_CARRY_EN
    assign out_c = bus.out_carry;
`else
    assign out_c = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        int           cyc;
    } rec_t;

    rec_t obs_q[$];
    int   in_cyc[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) in_cyc.push_back(cyc);
            if (bus.out_valid && bus.out_ready) obs_q.push_back('{d: bus.out_data, c: out_c, cyc: cyc});
        end
        cyc++;
    end

    function automatic logic [W-1:0] ref_data(logic [W-1:0] d, int a, logic [1:0] m);
        logic signed [W-1:0] sd;
        sd = d;
        case (m)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return sd >>> a;
            default: return a == 0 ? d : (d >> a) | (d << (W - a));
        endcase
    endfunction

    function automatic logic ref_carry(logic [W-1:0] d, int a, logic [1:0] m);
        logic [W-1:0] r;
        if (a == 0) return 1'b0;
        if (m == 2'b00) return d[W-a];
        if (m == 2'b11) begin
            r = ref_data(d, a, m);
            return r[W-1];
        end
        return d[a-1];
    endfunction

    task automatic send(input logic [W-1:0] d, input int a, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = 4'(a);
        bus.in_mode  = m;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n);
        for (int k = 0; k < 200 && obs_q.size() < n; k++) @(posedge clk);
        #1;
        total++;
        if (obs_q.size() < n) begin
            bad++;
            $display("FAIL drain_count got=%0d want=%0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want 0", bus.out_valid); end
        total++;
        if (bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h want 0000", bus.out_data); end
`ifdef BSHIFT_PIPE_CARRY_EN
        total++;
        if (out_c !== 1'b0) begin bad++; $display("FAIL rst_out_carry got=%b want 0", out_c); end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want 1", bus.in_ready); end
    endtask

    task automatic test_walk();
        logic [W-1:0] e;
        obs_q.delete();
        in_cyc.delete();
        bus.out_ready = 1'b1;
        for (int a = 0; a < W; a++) send(16'h0001, a, 2'b00);
        bus.in_valid = 1'b0;
        wait_obs(W);
        for (int j = 0; j < W && j < obs_q.size(); j++) begin
            e = 16'h0001;
            e = e << j;
            total++;
            if (obs_q[j].d !== e) begin bad++; $display("FAIL walk_data[%0d] got=%h want=%h", j, obs_q[j].d, e); end
            total++;
            if (obs_q[j].cyc - in_cyc[j] !== 2) begin
                bad++;
                $display("FAIL walk_latency[%0d] got=%0d want=2", j, obs_q[j].cyc - in_cyc[j]);
            end
        end
    endtask

    task automatic test_modes();
        logic [W-1:0] ind  [6] = '{16'hF00B, 16'hF00B, 16'hF00B, 16'hF00B, 16'h00FF, 16'h00FF};
        int           amt  [6] = '{4, 4, 4, 4, 2, 0};
        logic [1:0]   md   [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
        logic [W-1:0] want [6] = '{16'h00B0, 16'h0F00, 16'hFF00, 16'hBF00, 16'hC03F, 16'h00FF};
        logic         wc   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        obs_q.delete();
        in_cyc.delete();
        bus.out_ready = 1'b1;
        for (int j = 0; j < 6; j++) send(ind[j], amt[j], md[j]);
        bus.in_valid = 1'b0;
        wait_obs(6);
        for (int j = 0; j < 6 && j < obs_q.size(); j++) begin
            total++;
            if (obs_q[j].d !== want[j]) begin bad++; $display("FAIL mode_data[%0d] got=%h want=%h", j, obs_q[j].d, want[j]); end
`ifdef BSHIFT_PIPE_CARRY_EN
            total++;
            if (obs_q[j].c !== wc[j]) begin bad++; $display("FAIL mode_carry[%0d] got=%b want=%b", j, obs_q[j].c, wc[j]); end
`else
            if (wc[j] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] bd [5];
        int           ba [5];
        logic [1:0]   bm [5];
        logic [W-1:0] first;
        logic         acc;
        int           i = 0;
        for (int j = 0; j < 5; j++) begin
            bd[j] = W'($urandom);
            ba[j] = $urandom_range(1, W - 1);
            bm[j] = 2'($urandom_range(0, 3));
        end
        first = ref_data(bd[0], ba[0], bm[0]);
        obs_q.delete();
        in_cyc.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = bd[0];
        bus.in_amt    = 4'(ba[0]);
        bus.in_mode   = bm[0];
        for (int c = 0; c < 40 && i < 5; c++) begin
            if (c == 4) bus.out_ready = 1'b1;
            @(negedge clk);
            acc = bus.in_ready;
            if (c == 2 || c == 3) begin
                total++;
                if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[c%0d] got=%b want 0", c, bus.in_ready); end
                total++;
                if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[c%0d] got=%b want 1", c, bus.out_valid); end
                total++;
                if (bus.out_data !== first) begin bad++; $display("FAIL bp_hold_data[c%0d] got=%h want=%h", c, bus.out_data, first); end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                if (i < 5) begin
                    bus.in_data = bd[i];
                    bus.in_amt  = 4'(ba[i]);
                    bus.in_mode = bm[i];
                end
            end
        end
        bus.in_valid = 1'b0;
        wait_obs(5);
        for (int j = 0; j < 5 && j < obs_q.size(); j++) begin
            total++;
            if (obs_q[j].d !== ref_data(bd[j], ba[j], bm[j])) begin
                bad++;
                $display("FAIL bp_order[%0d] got=%h want=%h", j, obs_q[j].d, ref_data(bd[j], ba[j], bm[j]));
            end
        end
    endtask

    task automatic test_throughput();
        logic [W-1:0] bd [16];
        int           ba [16];
        logic [1:0]   bm [16];
        obs_q.delete();
        in_cyc.delete();
        bus.out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            bd[j] = W'($urandom);
            ba[j] = $urandom_range(0, W - 1);
            bm[j] = 2'($urandom_range(0, 3));
            send(bd[j], ba[j], bm[j]);
        end
        bus.in_valid = 1'b0;
        wait_obs(16);
        for (int j = 0; j < 16 && j < obs_q.size(); j++) begin
            total++;
            if (obs_q[j].d !== ref_data(bd[j], ba[j], bm[j])) begin
                bad++;
                $display("FAIL tp_data[%0d] got=%h want=%h", j, obs_q[j].d, ref_data(bd[j], ba[j], bm[j]));
            end
`ifdef BSHIFT_PIPE_CARRY_EN
            total++;
            if (obs_q[j].c !== ref_carry(bd[j], ba[j], bm[j])) begin
                bad++;
                $display("FAIL tp_carry[%0d] got=%b want=%b", j, obs_q[j].c, ref_carry(bd[j], ba[j], bm[j]));
            end
`endif
            total++;
            if (obs_q[j].cyc !== in_cyc[0] + 2 + j) begin
                bad++;
                $display("FAIL tp_cycle[%0d] got=%0d want=%0d", j, obs_q[j].cyc, in_cyc[0] + 2 + j);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        in_cyc.delete();
        bus.out_ready = 1'b0;
        send(W'($urandom), $urandom_range(0, W - 1), 2'($urandom_range(0, 3)));
        send(W'($urandom), $urandom_range(0, W - 1), 2'($urandom_range(0, 3)));
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b want 1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b want 0", bus.out_valid); end
        total++;
        if (bus.out_data !== '0) begin bad++; $display("FAIL rm_out_data got=%h want 0000", bus.out_data); end
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready got=%b want 1", bus.in_ready); end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (obs_q.size() !== 0) begin bad++; $display("FAIL rm_stale_beats got=%0d want 0", obs_q.size()); end
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_idle_valid got=%b want 0", bus.out_valid); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = 2'b00;
        bus.out_ready = 1'b0;
        test_reset();
        test_walk();
        test_modes();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bshift_pipe.md
Name: bshift_pipe

Overview:
- Parametrised, pipelined barrel shifter; successor to the combinational left/right shifters.
- Single datapath supports four modes: logical left, logical right, arithmetic right and rotate right.
- Registered log2(WIDTH) shift network, split across STAGES pipeline stages, with valid/ready handshake on both sides and full backpressure.
- Sits between register-file read and writeback in datapath blocks; sustains one result per cycle.

Parameters:
- WIDTH, 16: data width; power of two, >= 2.
- STAGES, 2: pipeline register stages; 1 <= STAGES <= $clog2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  $clog2(WIDTH)  shift amount, unsigned.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  shifted result.

Behaviour:
- Reset: asynchronous, active-high. While rst is high, all stage valid flags = 0, out_valid = 0 and out_data = 0. Stage data registers are also cleared to 0. in_ready = 1 one cycle after rst deasserts; it is combinational from stage state.
- Shift network:
  - L = $clog2(WIDTH) levels; level k shifts by 2^k when in_amt[k] = 1.
  - Stage s (0-based) implements levels floor(s*L/STAGES) to floor((s+1)*L/STAGES)-1, then registers.
  - in_amt, in_mode and the sign bit in_data[WIDTH-1] are carried alongside the data in every stage.
- Modes:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the original in_data[WIDTH-1].
  - ROR: bits leaving at the LSB re-enter at the MSB.
  - in_amt = 0 passes the data unchanged in every mode.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data, out_valid and the flag stay stable while out_valid && !out_ready.
- Pipeline advance (bubble-collapsing):
  - Stage s loads from stage s-1 (stage 0 loads from the input) when stage s is empty, or when stage s+1 will accept its contents this cycle.
  - The last stage accepts when it is empty or out_ready = 1.
  - in_ready = stage 0 empty, or stage 0 advancing.
- Latency: exactly STAGES cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle with out_ready held high.
- Capacity: at most STAGES beats in flight. With out_ready low, in_ready drops only once every stage holds a valid beat.
- Ordering: strict FIFO order; no beat is dropped or duplicated.
- Simultaneous output and input transfer on a full pipeline: both complete in the same cycle, and occupancy is unchanged.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: BSHIFT_PIPE_CARRY_EN.
- Defined: adds output port out_carry (1 bit), aligned with out_data and reset to 0. Value is the last bit shifted out:
  - SLL: in_data[WIDTH-in_amt].
  - SRL and SRA: in_data[in_amt-1].
  - ROR: result bit WIDTH-1.
  - out_carry = 0 when in_amt = 0.
- Not defined: the port is absent and no carry logic is built.

Test Plan:
- Single-bit walk: SLL, in_data=16'h0001, in_amt 0..15 -> out_data = 1<<amt, each appearing exactly 2 cycles after acceptance (STAGES=2).
- Mode sweep: in_data=16'hF00B, in_amt=4 -> SLL 16'h00B0, SRL 16'h0F00, SRA 16'hFF00, ROR 16'hBF00. With BSHIFT_PIPE_CARRY_EN, carry is 1 for SLL, SRL and SRA, and 1 for ROR (bit 15 of 16'hBF00).
- Rotate and pass-through: 16'h00FF ROR 2 -> 16'hC03F; 16'h00FF SLL 0 -> 16'h00FF, carry 0.
- Backpressure: push 5 back-to-back beats with out_ready=0 for 4 cycles -> in_ready low after 2 beats held. out_data stable while stalled. All 5 results emerge in order once out_ready=1, with none lost.
- Throughput: 16 random beats, out_ready=1 -> out_valid continuous for 16 cycles starting at cycle 2. Results match a reference model.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 and out_data=0 immediately. No stale beat appears after release; in_ready=1 on the next cycle.
